// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the simpleCPU instruction sequencer:
// opcodes, one-hot state encoding and strobe bundle bit positions.
package cpu_ctrl_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_HLT = 3'b000;
    localparam op_t OP_SKZ = 3'b001;
    localparam op_t OP_ADD = 3'b010;
    localparam op_t OP_AND = 3'b011;
    localparam op_t OP_XOR = 3'b100;
    localparam op_t OP_LDA = 3'b101;
    localparam op_t OP_STO = 3'b110;
    localparam op_t OP_JMP = 3'b111;

    typedef logic [9:0] state_t;

    localparam logic [9:0] ST_IDLE = 10'b00_0000_0001;
    localparam logic [9:0] ST_S0   = 10'b00_0000_0010;
    localparam logic [9:0] ST_S1   = 10'b00_0000_0100;
    localparam logic [9:0] ST_S2   = 10'b00_0000_1000;
    localparam logic [9:0] ST_S3   = 10'b00_0001_0000;
    localparam logic [9:0] ST_S4   = 10'b00_0010_0000;
    localparam logic [9:0] ST_S5   = 10'b00_0100_0000;
    localparam logic [9:0] ST_S6   = 10'b00_1000_0000;
    localparam logic [9:0] ST_S7   = 10'b01_0000_0000;
    localparam logic [9:0] ST_HALT = 10'b10_0000_0000;

    localparam int STB_INC_PC   = 0;
    localparam int STB_LOAD_PC  = 1;
    localparam int STB_LOAD_IR  = 2;
    localparam int STB_LOAD_ACC = 3;
    localparam int STB_RD       = 4;
    localparam int STB_WR       = 5;
    localparam int STB_DATACTL  = 6;
    localparam int STB_HALT     = 7;
    localparam int STB_W        = 8;

    typedef logic [STB_W-1:0] strobe_t;

    // Opcodes that read an operand from memory into the accumulator.
    function automatic logic is_alu(op_t op);
        return op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Phase-in / strobe-out bundle between phase generator, sequencer and datapath.
// SEQ_RESUME_EN adds the resume input used to leave HALT.
interface instr_sequencer_if #(
    parameter int OP_W = 3
) ();

    logic            fetch;
    logic [OP_W-1:0] opcode;
    logic            zero;
`ifdef SEQ_RESUME_EN
    logic            resume;
`endif
    logic            inc_pc;
    logic            load_pc;
    logic            load_ir;
    logic            load_acc;
    logic            rd;
    logic            wr;
    logic            datactl_ena;
    logic            halt;

    modport master (
        input  fetch, opcode, zero,
`ifdef SEQ_RESUME_EN
        input  resume,
`endif
        output inc_pc, load_pc, load_ir, load_acc,
        output rd, wr, datactl_ena, halt
    );

    modport slave (
        output fetch, opcode, zero,
`ifdef SEQ_RESUME_EN
        output resume,
`endif
        input  inc_pc, load_pc, load_ir, load_acc,
        input  rd, wr, datactl_ena, halt
    );

endinterface

// File: rtl/instr_strobe_decode.sv
// Combinational map from (state, latched opcode, latched zero) to the
// control strobe vector; the sequencer registers the result.
module instr_strobe_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t  state_i,
    input  op_t     op_i,
    input  logic    zero_i,
    output strobe_t strobe_o
);

    logic alu;
    logic skip;

    assign alu  = is_alu(op_i);
    assign skip = (op_i == OP_SKZ) && zero_i;

    always_comb begin
        strobe_o = '0;
        case (state_i)
            ST_S0: begin
                strobe_o[STB_RD]      = 1'b1;
                strobe_o[STB_LOAD_IR] = 1'b1;
            end
            ST_S1: begin
                strobe_o[STB_RD]      = 1'b1;
                strobe_o[STB_LOAD_IR] = 1'b1;
                strobe_o[STB_INC_PC]  = 1'b1;
            end
            ST_S3: begin
                strobe_o[STB_HALT]   = (op_i == OP_HLT);
                strobe_o[STB_INC_PC] = (op_i != OP_HLT);
            end
            ST_S4: begin
                strobe_o[STB_RD]      = alu;
                strobe_o[STB_LOAD_PC] = (op_i == OP_JMP);
                strobe_o[STB_DATACTL] = (op_i == OP_STO);
            end
            ST_S5: begin
                strobe_o[STB_RD]       = alu;
                strobe_o[STB_LOAD_ACC] = alu;
                strobe_o[STB_LOAD_PC]  = (op_i == OP_JMP);
                strobe_o[STB_INC_PC]   = skip || (op_i == OP_JMP);
                strobe_o[STB_DATACTL]  = (op_i == OP_STO);
                strobe_o[STB_WR]       = (op_i == OP_STO);
            end
            ST_S6: begin
                strobe_o[STB_RD]      = alu;
                strobe_o[STB_DATACTL] = (op_i == OP_STO);
            end
            ST_S7: begin
                strobe_o[STB_INC_PC] = skip;
            end
            ST_HALT: begin
                strobe_o[STB_HALT] = 1'b1;
            end
            default: begin
                strobe_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// simpleCPU 8-step instruction-cycle strobe sequencer with registered outputs.
// SEQ_RESUME_EN: when defined, resume=1 in HALT restarts at S0.
module instr_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter bit AUTO_START = 1'b0,
    parameter int OP_W       = 3
) (
    input  logic                clk,
    input  logic                rst,
    instr_sequencer_if.master   bus
);

    if (OP_W != 3) begin : g_op_w_chk
        $error("instr_sequencer: OP_W must be 3");
    end

    state_t  state_q, state_d;
    logic    running_q, running_d;
    op_t     op_q, op_d;
    logic    zero_q, zero_d;
    strobe_t strobe_q, strobe_d;

    always_comb begin
        state_d   = state_q;
        running_d = running_q;
        op_d      = op_q;
        zero_d    = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (!running_q && (bus.fetch || AUTO_START)) begin
                    state_d   = ST_S0;
                    running_d = 1'b1;
                end
            end
            ST_S0: state_d = ST_S1;
            ST_S1: state_d = ST_S2;
            ST_S2: begin
                state_d = ST_S3;
                op_d    = bus.opcode;
            end
            ST_S3: begin
                state_d = (op_q == OP_HLT) ? ST_HALT : ST_S4;
            end
            ST_S4: begin
                state_d = ST_S5;
                zero_d  = bus.zero;
            end
            ST_S5: state_d = ST_S6;
            ST_S6: state_d = ST_S7;
            ST_S7: state_d = ST_S0;
            ST_HALT: begin
`ifdef SEQ_RESUME_EN
                if (bus.resume) begin
                    state_d = ST_S0;
                end
`endif
            end
            default: begin
                state_d   = ST_IDLE;
                running_d = 1'b0;
            end
        endcase
    end

    // Decode the upcoming state so the registered strobes line up with it.
    instr_strobe_decode u_decode (
        .state_i  (state_d),
        .op_i     (op_d),
        .zero_i   (zero_d),
        .strobe_o (strobe_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            op_q      <= OP_HLT;
            zero_q    <= 1'b0;
            strobe_q  <= '0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            op_q      <= op_d;
            zero_q    <= zero_d;
            strobe_q  <= strobe_d;
        end
    end

    assign bus.inc_pc      = strobe_q[STB_INC_PC];
    assign bus.load_pc     = strobe_q[STB_LOAD_PC];
    assign bus.load_ir     = strobe_q[STB_LOAD_IR];
    assign bus.load_acc    = strobe_q[STB_LOAD_ACC];
    assign bus.rd          = strobe_q[STB_RD];
    assign bus.wr          = strobe_q[STB_WR];
    assign bus.datactl_ena = strobe_q[STB_DATACTL];
    assign bus.halt        = strobe_q[STB_HALT];

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: step-counter reference model compared every
// cycle, directed per-instruction strobe masks, reset and random phases.
module tb_instr_sequencer;

    localparam bit AUTO = 1'b0;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    // bit positions of the observed vector
    localparam int I_INC  = 0;
    localparam int I_LPC  = 1;
    localparam int I_LIR  = 2;
    localparam int I_LACC = 3;
    localparam int I_RD   = 4;
    localparam int I_WR   = 5;
    localparam int I_DC   = 6;
    localparam int I_HALT = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;

    instr_sequencer_if #(.OP_W(3)) bus ();

    instr_sequencer #(
        .AUTO_START (AUTO),
        .OP_W       (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] dv;
    assign dv = {bus.halt, bus.datactl_ena, bus.wr, bus.rd,
                 bus.load_acc, bus.load_ir, bus.load_pc, bus.inc_pc};

    task automatic check(input string name, input logic [7:0] got,
                         input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: step -1 = idle, 0..7 = instruction step, 8 = halted
    int         m_step;
    logic [2:0] m_op;
    logic       m_z;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_step <= -1;
            m_op   <= HLT;
            m_z    <= 1'b0;
        end else if (m_step == -1) begin
            if (bus.fetch || AUTO) m_step <= 0;
        end else if (m_step == 8) begin
`ifdef SEQ_RESUME_EN
            if (bus.resume) m_step <= 0;
`endif
        end else if (m_step == 3 && m_op == HLT) begin
            m_step <= 8;
        end else begin
            if (m_step == 2) m_op <= bus.opcode;
            if (m_step == 4) m_z <= bus.zero;
            m_step <= (m_step + 1) % 8;
        end
    end

    function automatic logic [7:0] expect_out(int step, logic [2:0] op,
                                              logic z);
        logic [7:0] e;
        bit mem_op;
        mem_op = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
        e = '0;
        case (step)
            0: begin e[I_RD] = 1; e[I_LIR] = 1; end
            1: begin e[I_RD] = 1; e[I_LIR] = 1; e[I_INC] = 1; end
            3: if (op == HLT) e[I_HALT] = 1; else e[I_INC] = 1;
            4: begin
                if (mem_op) e[I_RD] = 1;
                if (op == JMP) e[I_LPC] = 1;
                if (op == STO) e[I_DC] = 1;
            end
            5: begin
                if (mem_op) begin e[I_RD] = 1; e[I_LACC] = 1; end
                if (op == SKZ && z) e[I_INC] = 1;
                if (op == JMP) begin e[I_LPC] = 1; e[I_INC] = 1; end
                if (op == STO) begin e[I_DC] = 1; e[I_WR] = 1; end
            end
            6: begin
                if (mem_op) e[I_RD] = 1;
                if (op == STO) e[I_DC] = 1;
            end
            7: if (op == SKZ && z) e[I_INC] = 1;
            8: e[I_HALT] = 1;
            default: e = '0;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        check("model", dv, expect_out(m_step, m_op, m_z));
    end

    // per-strobe masks over one instruction, bit s = value in step s
    logic [7:0] mk [8];

    task automatic run_instr(input logic [2:0] op, input logic z);
        bus.opcode = op;
        bus.zero   = z;
        for (int b = 0; b < 8; b++) mk[b] = '0;
        for (int s = 0; s < 8; s++) begin
            for (int b = 0; b < 8; b++) mk[b][s] = dv[b];
            @(negedge clk);
        end
    endtask

    task automatic start_seq();
        bus.fetch = 1'b1;
        @(negedge clk);
        bus.fetch = 1'b0;
    endtask

    initial begin
        bus.fetch  = 1'b0;
        bus.opcode = LDA;
        bus.zero   = 1'b0;
`ifdef SEQ_RESUME_EN
        bus.resume = 1'b0;
`endif
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_out", dv, 8'h00);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_out", dv, 8'h00);

        start_seq();
        check("first_s0", dv, 8'h14);

        run_instr(LDA, 1'b0);
        check("lda_rd", mk[I_RD], 8'h73);
        check("lda_lir", mk[I_LIR], 8'h03);
        check("lda_inc", mk[I_INC], 8'h0A);
        check("lda_lacc", mk[I_LACC], 8'h20);
        check("lda_wr", mk[I_WR], 8'h00);

        run_instr(ADD, 1'b1);
        check("add_rd", mk[I_RD], 8'h73);
        check("add_lacc", mk[I_LACC], 8'h20);

        run_instr(STO, 1'b0);
        check("sto_wr", mk[I_WR], 8'h20);
        check("sto_dc", mk[I_DC], 8'h70);
        check("sto_rd", mk[I_RD], 8'h03);

        run_instr(SKZ, 1'b1);
        check("skz1_inc", mk[I_INC], 8'hAA);

        run_instr(SKZ, 1'b0);
        check("skz0_inc", mk[I_INC], 8'h0A);

        run_instr(JMP, 1'b1);
        check("jmp_lpc", mk[I_LPC], 8'h30);
        check("jmp_inc", mk[I_INC], 8'h2A);
        check("jmp_rd", mk[I_RD], 8'h03);

        run_instr(XOR, 1'b1);
        check("xor_lacc", mk[I_LACC], 8'h20);
        check("xor_lpc", mk[I_LPC], 8'h00);

        run_instr(HLT, 1'b0);
        check("hlt_halt", mk[I_HALT], 8'hF8);
        check("hlt_inc", mk[I_INC], 8'h02);
        for (int i = 0; i < 20; i++) begin
            check("halt_hold", dv, 8'h80);
            @(negedge clk);
        end
`ifdef SEQ_RESUME_EN
        bus.resume = 1'b1;
        @(negedge clk);
        bus.resume = 1'b0;
        check("resume_s0", dv, 8'h14);
        run_instr(LDA, 1'b0);
        check("resume_rd", mk[I_RD], 8'h73);
`endif

        // reset in the middle of an ADD
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        bus.opcode = ADD;
        start_seq();
        repeat (5) @(negedge clk);
        check("add_s5", dv, 8'h18);
        #2 rst = 1'b1;
        #1 check("rst_async", dv, 8'h00);
        @(negedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_wait", dv, 8'h00);
        end
        start_seq();
        check("restart_s0", dv, 8'h14);

        // random phase, checked by the model process
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            bus.opcode = ($urandom_range(0, 15) == 0) ? HLT
                         : 3'($urandom_range(1, 7));
            bus.zero   = 1'($urandom_range(0, 1));
            bus.fetch  = 1'($urandom_range(0, 1));
`ifdef SEQ_RESUME_EN
            bus.resume = ($urandom_range(0, 3) == 0);
`else
            if (m_step == 8 && $urandom_range(0, 5) == 0) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
`endif
            if ($urandom_range(0, 99) == 0) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
